// File: rtl/wb_shared_bus_pkg.sv
// Shared definitions for the round-robin Wishbone shared bus: FSM encoding,
// default geometry and a constant-evaluable ceil(log2) helper.
package wb_shared_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int DEF_NM = 4;
  localparam int DEF_NS = 8;
  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
  localparam int DEF_SW = 3;
  localparam int DEF_TO = 255;

  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_i, wrapping.
// Output is one-hot, or all zero when disabled or nobody requests.
module wb_rr_arbiter
  import wb_shared_bus_pkg::*;
#(
  parameter  int NM = DEF_NM,
  localparam int LW = (NM > 1) ? clog2(NM) : 1
) (
  input  logic [NM-1:0] req_i,
  input  logic [LW-1:0] last_i,
  input  logic          en_i,
  output logic [NM-1:0] gnt_o
);

  always_comb begin
    logic found;
    int   pos;
    gnt_o = '0;
    found = 1'b0;
    pos   = 0;
    // Offset 1 is checked first so the previous owner has lowest priority.
    for (int i = 1; i <= NM; i++) begin
      pos = (int'(last_i) + i) % NM;
      for (int j = 0; j < NM; j++) begin
        if (en_i && !found && (j == pos) && req_i[j]) begin
          gnt_o[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_shared_bus_rr.sv
// Wishbone shared bus, NM masters x NS slaves, registered round-robin grant.
// Define WB_SHARED_BUS_TIMEOUT_EN to add the silent-slave watchdog.
module wb_shared_bus_rr
  import wb_shared_bus_pkg::*;
#(
  parameter int NM        = DEF_NM,
  parameter int NS        = DEF_NS,
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int SW        = DEF_SW,
  parameter int TO_CYCLES = DEF_TO
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NM-1:0]      m_cyc_i,
  input  logic [NM-1:0]      m_stb_i,
  input  logic [NM-1:0]      m_we_i,
  input  logic [NM*AW-1:0]   m_adr_i,
  input  logic [NM*DW/8-1:0] m_sel_i,
  input  logic [NM*DW-1:0]   m_dat_i,
  output logic [DW-1:0]      m_dat_o,
  output logic [NM-1:0]      m_ack_o,
  output logic [NM-1:0]      m_err_o,
  output logic               s_cyc_o,
  output logic [NS-1:0]      s_stb_o,
  output logic               s_we_o,
  output logic [AW-1:0]      s_adr_o,
  output logic [DW/8-1:0]    s_sel_o,
  output logic [DW-1:0]      s_dat_o,
  input  logic [NS*DW-1:0]   s_dat_i,
  input  logic [NS-1:0]      s_ack_i,
  input  logic [NS-1:0]      s_err_i,
  output logic [NM-1:0]      gnt_o
);

  localparam int LW = (NM > 1) ? clog2(NM) : 1;
  localparam int BW = DW / 8;

  state_e        state_q;
  logic [NM-1:0] gnt_q, arbGnt;
  logic [LW-1:0] grantIdx_q, lastIdx_q, arbIdx;
  logic          busy, gCyc, gStb, gWe, reqStb;
  logic [AW-1:0] gAdr;
  logic [BW-1:0] gSel;
  logic [DW-1:0] gDat, sDat;
  logic [SW-1:0] slvIdx;
  logic [NS-1:0] stbVec;
  logic          mapped, sAck, sErr, anyErr, ackOut, toHit;
  logic          unmErr_q, unmErr_d;

  assign busy = (state_q == BUSY);

  wb_rr_arbiter #(.NM(NM)) uArb (
    .req_i (m_cyc_i),
    .last_i(lastIdx_q),
    .en_i  (!busy),
    .gnt_o (arbGnt)
  );

  always_comb begin
    arbIdx = '0;
    for (int j = 0; j < NM; j++) if (arbGnt[j]) arbIdx = LW'(j);
  end

  // Master-side mux; everything reads zero outside BUSY so reset clears the bus.
  always_comb begin
    gCyc = 1'b0;
    gStb = 1'b0;
    gWe  = 1'b0;
    gAdr = '0;
    gSel = '0;
    gDat = '0;
    for (int j = 0; j < NM; j++) begin
      if (busy && grantIdx_q == LW'(j)) begin
        gCyc = m_cyc_i[j];
        gStb = m_stb_i[j];
        gWe  = m_we_i[j];
        gAdr = m_adr_i[j*AW +: AW];
        gSel = m_sel_i[j*BW +: BW];
        gDat = m_dat_i[j*DW +: DW];
      end
    end
  end

  assign slvIdx = gAdr[AW-1:AW-SW];
  assign reqStb = gCyc & gStb;

  always_comb begin
    mapped = 1'b0;
    sAck   = 1'b0;
    sErr   = 1'b0;
    sDat   = '0;
    stbVec = '0;
    for (int i = 0; i < NS; i++) begin
      if (busy && slvIdx == SW'(i)) begin
        mapped    = 1'b1;
        sAck      = s_ack_i[i];
        sErr      = s_err_i[i];
        sDat      = s_dat_i[i*DW +: DW];
        stbVec[i] = reqStb;
      end
    end
  end

  // Unmapped error toggles off after one cycle so a held strobe sees a single pulse.
  assign unmErr_d = reqStb & ~mapped & ~unmErr_q;

`ifdef WB_SHARED_BUS_TIMEOUT_EN
  localparam int CW = clog2(TO_CYCLES + 1);
  logic [CW-1:0] toCnt_q, toCnt_d;

  assign toHit = (toCnt_q == CW'(TO_CYCLES));

  always_comb begin
    toCnt_d = toCnt_q + CW'(1);
    if (!reqStb || sAck || sErr || unmErr_q || toHit) toCnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) toCnt_q <= '0;
    else      toCnt_q <= toCnt_d;
  end
`else
  assign toHit = 1'b0;
`endif

  assign anyErr  = sErr | unmErr_q | toHit;
  assign ackOut  = sAck & ~anyErr;
  assign m_ack_o = gnt_q & {NM{ackOut}};
  assign m_err_o = gnt_q & {NM{anyErr}};
  assign m_dat_o = sDat;
  assign s_cyc_o = gCyc;
  assign s_stb_o = toHit ? '0 : stbVec;
  assign s_we_o  = gWe;
  assign s_adr_o = gAdr;
  assign s_sel_o = gSel;
  assign s_dat_o = gDat;
  assign gnt_o   = gnt_q;

  // Grant is held for the whole cyc so block and RMW cycles stay locked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      grantIdx_q <= '0;
      lastIdx_q  <= LW'(NM - 1);
      unmErr_q   <= 1'b0;
    end else begin
      unmErr_q <= unmErr_d;
      case (state_q)
        IDLE: begin
          if (|m_cyc_i) begin
            state_q    <= BUSY;
            gnt_q      <= arbGnt;
            grantIdx_q <= arbIdx;
          end
        end
        BUSY: begin
          if (!gCyc) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            lastIdx_q <= grantIdx_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_shared_bus_rr.sv
// Scoreboard bench for wb_shared_bus_rr (NM=4, NS=6, TO_CYCLES=8); the
// timeout scenario runs only when WB_SHARED_BUS_TIMEOUT_EN is defined.
module tb_wb_shared_bus_rr;

  typedef struct {
    int          m;
    logic        isErr;
    logic [5:0]  stb;
    logic        chk;
    logic [31:0] dat;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  m_cyc_i, m_stb_i, m_we_i;
  logic [127:0] m_adr_i, m_dat_i;
  logic [15:0] m_sel_i;
  logic [31:0] m_dat_o, s_adr_o, s_dat_o;
  logic [3:0]  m_ack_o, m_err_o, gnt_o, s_sel_o;
  logic        s_cyc_o, s_we_o;
  logic [5:0]  s_stb_o, s_ack_i, s_err_i, respQ;
  logic [191:0] s_dat_i;
  logic        silent5 = 1'b0;
  bit          monResp = 1'b1;

  logic        mCyc [4];
  logic        mStb [4];
  logic        mWe  [4];
  logic [31:0] mAdr [4];
  logic [31:0] mDat [4];
  logic [3:0]  mSel [4];
  logic [31:0] mem  [6][16];

  int    total = 0;
  int    bad = 0;
  int    expGnt[$];
  resp_t expResp[$];
  logic [3:0] prevGnt = '0;

  logic [31:0] t4Adr [4] = '{32'hE000_0000, 32'hC000_0000, 32'hA000_0000, 32'h8000_0000};
  logic        t4Err [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic [5:0]  t4Stb [4] = '{6'h00, 6'h00, 6'h20, 6'h10};

  wb_shared_bus_rr #(.NM(4), .NS(6), .AW(32), .DW(32), .SW(3), .TO_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i),
    .m_sel_i(m_sel_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .m_err_o(m_err_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .gnt_o(gnt_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      m_cyc_i[k]          = mCyc[k];
      m_stb_i[k]          = mStb[k];
      m_we_i[k]           = mWe[k];
      m_adr_i[k*32 +: 32] = mAdr[k];
      m_dat_i[k*32 +: 32] = mDat[k];
      m_sel_i[k*4 +: 4]   = mSel[k];
    end
  end

  // Slave models: registered single-cycle response; slave 4 answers with err.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      respQ <= '0;
      for (int i = 0; i < 6; i++)
        for (int w = 0; w < 16; w++) mem[i][w] <= 32'h5000_0000 + 32'(i * 256 + w);
    end else begin
      for (int i = 0; i < 6; i++) begin
        respQ[i] <= s_stb_o[i] & ~respQ[i] & ~(i == 5 && silent5);
        if (s_stb_o[i] && s_we_o && !respQ[i])
          for (int b = 0; b < 4; b++)
            if (s_sel_o[b]) mem[i][s_adr_o[5:2]][b*8 +: 8] <= s_dat_o[b*8 +: 8];
      end
    end
  end

  assign s_ack_i = respQ & 6'b101111;
  assign s_err_i = respQ & 6'b010000;

  always_comb begin
    for (int i = 0; i < 6; i++) s_dat_i[i*32 +: 32] = mem[i][s_adr_o[5:2]];
  end

  // Monitor: grant order/dead cycle and per-transfer responses against the queues.
  always @(negedge clk) begin
    if (gnt_o != prevGnt && gnt_o != 4'b0) begin
      total++;
      if (expGnt.size() == 0) begin
        bad++;
        $display("[TB] FAIL grant: got %b, none expected", gnt_o);
      end else begin
        int e;
        e = expGnt.pop_front();
        if (prevGnt != 4'b0 || gnt_o != 4'(1 << e)) begin
          bad++;
          $display("[TB] FAIL grant: got %b after %b, expected %b after 0000", gnt_o, prevGnt, 4'(1 << e));
        end
      end
    end
    prevGnt = gnt_o;
    for (int k = 0; k < 4; k++) begin
      if (monResp && (m_ack_o[k] || m_err_o[k])) begin
        total++;
        if (expResp.size() == 0) begin
          bad++;
          $display("[TB] FAIL resp: master %0d ack=%b err=%b, none expected", k, m_ack_o[k], m_err_o[k]);
        end else begin
          resp_t r;
          r = expResp.pop_front();
          if (r.m != k || m_err_o[k] != r.isErr || m_ack_o[k] == r.isErr ||
              s_stb_o != r.stb || (r.chk && m_dat_o != r.dat)) begin
            bad++;
            $display("[TB] FAIL resp: m=%0d err=%b stb=%h dat=%h, expected m=%0d err=%b stb=%h dat=%h",
                     k, m_err_o[k], s_stb_o, m_dat_o, r.m, r.isErr, r.stb, r.dat);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pushResp(input int m, input logic isErr, input logic [5:0] stb,
                          input logic chk, input logic [31:0] dat);
    resp_t r;
    r.m = m; r.isErr = isErr; r.stb = stb; r.chk = chk; r.dat = dat;
    expResp.push_back(r);
  endtask

  // One master cycle of n transfers at consecutive word addresses, then one idle cycle.
  task automatic applyStimulus(input int k, input int n, input logic we, input logic [31:0] adr,
                               input logic [31:0] dat, input logic [3:0] sel, output int cycles);
    logic [1:0] kk;
    bit done;
    int waited;
    kk = k[1:0];
    cycles = 0;
    mCyc[kk] = 1'b1; mStb[kk] = 1'b1; mWe[kk] = we; mSel[kk] = sel;
    for (int t = 0; t < n; t++) begin
      mAdr[kk] = adr + 32'(4 * t);
      mDat[kk] = dat + 32'(t);
      done = 1'b0;
      waited = 0;
      while (!done && waited < 100) begin
        @(negedge clk);
        waited++;
        cycles++;
        if (m_ack_o[kk] || m_err_o[kk]) done = 1'b1;
      end
      if (!done) begin
        total++;
        bad++;
        $display("[TB] FAIL timeout: master %0d got no response in %0d cycles, expected one", k, waited);
      end
      @(posedge clk); #1;
    end
    mCyc[kk] = 1'b0; mStb[kk] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int c0, c1, c2, c3;
    for (int k = 0; k < 4; k++) begin
      mCyc[k] = 1'b0; mStb[k] = 1'b0; mWe[k] = 1'b0;
      mAdr[k] = '0; mDat[k] = '0; mSel[k] = '0;
    end
    repeat (2) @(negedge clk);
    checkOutput("reset gnt", 32'(gnt_o), 32'h0);
    checkOutput("reset s_cyc/s_stb", {25'b0, s_cyc_o, s_stb_o}, 32'h0);
    checkOutput("reset ack/err", {24'b0, m_ack_o, m_err_o}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single master write/read");
    expGnt.push_back(0);
    pushResp(0, 1'b0, 6'h01, 1'b0, 32'h0);
    fork
      applyStimulus(0, 1, 1'b1, 32'h0000_0000, 32'h0000_DEAD, 4'b1111, c0);
      begin
        @(negedge clk); checkOutput("gnt same cycle as cyc", 32'(gnt_o), 32'h0);
        @(negedge clk); checkOutput("gnt one cycle later", 32'(gnt_o), 32'h1);
      end
    join
    expGnt.push_back(0);
    pushResp(0, 1'b0, 6'h01, 1'b1, 32'h0000_DEAD);
    applyStimulus(0, 1, 1'b0, 32'h0000_0000, 32'h0, 4'b1111, c0);
    expGnt.push_back(0);
    pushResp(0, 1'b0, 6'h01, 1'b0, 32'h0);
    applyStimulus(0, 1, 1'b1, 32'h0000_0000, 32'h1234_5678, 4'b1100, c0);
    expGnt.push_back(0);
    pushResp(0, 1'b0, 6'h01, 1'b1, 32'h1234_DEAD);
    applyStimulus(0, 1, 1'b0, 32'h0000_0000, 32'h0, 4'b1111, c0);

    $display("[TB] four simultaneous masters, two rounds");
    applyReset();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        expGnt.push_back(k);
        pushResp(k, 1'b0, 6'(1 << k), r == 1, 32'hC0DE_0000 + 32'(k));
      end
      fork
        applyStimulus(0, 1, r == 0, 32'h0000_0004, 32'hC0DE_0000, 4'hF, c0);
        applyStimulus(1, 1, r == 0, 32'h2000_0004, 32'hC0DE_0001, 4'hF, c1);
        applyStimulus(2, 1, r == 0, 32'h4000_0004, 32'hC0DE_0002, 4'hF, c2);
        applyStimulus(3, 1, r == 0, 32'h6000_0004, 32'hC0DE_0003, 4'hF, c3);
      join
    end

    $display("[TB] locked burst on master 2 with master 1 waiting");
    applyReset();
    expGnt.push_back(2);
    expGnt.push_back(1);
    for (int w = 0; w < 4; w++) pushResp(2, 1'b0, 6'h02, 1'b1, 32'h5000_0100 + 32'(w));
    pushResp(1, 1'b0, 6'h04, 1'b0, 32'h0);
    fork
      applyStimulus(2, 4, 1'b0, 32'h2000_0000, 32'h0, 4'hF, c2);
      begin
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1, 1, 1'b1, 32'h4000_0000, 32'hAAAA_5555, 4'hF, c1);
      end
    join

    $display("[TB] unmapped, boundary and slave-error accesses");
    applyReset();
    for (int i = 0; i < 4; i++) begin
      expGnt.push_back(0);
      pushResp(0, t4Err[i], t4Stb[i], i == 2, 32'h5000_0500);
      applyStimulus(0, 1, 1'b0, t4Adr[i], 32'h0, 4'hF, c0);
      if (i == 0) checkOutput("unmapped err latency", 32'(c0), 32'd3);
    end

`ifdef WB_SHARED_BUS_TIMEOUT_EN
    $display("[TB] silent slave watchdog");
    applyReset();
    silent5 = 1'b1;
    expGnt.push_back(0);
    expGnt.push_back(1);
    pushResp(0, 1'b1, 6'h00, 1'b0, 32'h0);
    pushResp(1, 1'b0, 6'h01, 1'b0, 32'h0);
    fork
      applyStimulus(0, 1, 1'b0, 32'hA000_0000, 32'h0, 4'hF, c0);
      begin
        @(posedge clk); #1;
        applyStimulus(1, 1, 1'b1, 32'h0000_0008, 32'h0BAD_F00D, 4'hF, c1);
      end
    join
    checkOutput("watchdog err cycle", 32'(c0), 32'd10);
    silent5 = 1'b0;
`endif

    $display("[TB] reset in the middle of a burst");
    applyReset();
    monResp = 1'b0;
    expGnt.push_back(2);
    mCyc[2] = 1'b1; mStb[2] = 1'b1; mWe[2] = 1'b0; mSel[2] = 4'hF; mAdr[2] = 32'h2000_0000;
    for (int w = 0; w < 10 && gnt_o != 4'b0100; w++) @(negedge clk);
    checkOutput("grant before reset", 32'(gnt_o), 32'h4);
    repeat (2) @(posedge clk);
    checkOutput("address before reset", s_adr_o, 32'h2000_0000);
    #2 rst = 1'b0;
    #1;
    checkOutput("reset gnt", 32'(gnt_o), 32'h0);
    checkOutput("reset strobes", {25'b0, s_cyc_o, s_stb_o}, 32'h0);
    checkOutput("reset ack/err", {24'b0, m_ack_o, m_err_o}, 32'h0);
    checkOutput("reset m_dat_o", m_dat_o, 32'h0);
    checkOutput("reset s_adr_o", s_adr_o, 32'h0);
    checkOutput("reset s_dat_o", s_dat_o, 32'h0);
    mCyc[2] = 1'b0; mStb[2] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    monResp = 1'b1;
    expGnt.push_back(0);
    expGnt.push_back(3);
    pushResp(0, 1'b0, 6'h01, 1'b0, 32'h0);
    pushResp(3, 1'b0, 6'h08, 1'b0, 32'h0);
    fork
      applyStimulus(0, 1, 1'b1, 32'h0000_0008, 32'h1111_0000, 4'hF, c0);
      applyStimulus(3, 1, 1'b1, 32'h6000_0008, 32'h3333_0000, 4'hF, c3);
    join

    repeat (2) @(negedge clk);
    checkOutput("grants left over", 32'(expGnt.size()), 32'd0);
    checkOutput("responses left over", 32'(expResp.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
